inv_byte_sub: RTL

INV_BYTE_SUB -- requirements
Module: inv_byte_sub

---
 rtl/aes_pkg.sv | 50 +++++
 rtl/inv_sbox.sv | 23 ++
 rtl/inv_byte_sub.sv | 119 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: state width, FSM state type and the byte substitution tables.
// Optional macro INV_BYTE_SUB_FWD_EN adds the forward SBOX table.
`timescale 1ns/1ps
package aes_pkg;

   localparam int AES_STATE_W = 128;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

`ifdef INV_BYTE_SUB_FWD_EN
   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };
`endif

   localparam logic [7:0] INV_SBOX [0:255] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

endpackage

// File: rtl/inv_sbox.sv
// Combinational single-byte substitution (InvSbox; forward Sbox selectable
// when INV_BYTE_SUB_FWD_EN is defined).
`timescale 1ns/1ps
module inv_sbox
   import aes_pkg::*;
(
   input  logic [7:0] din,
`ifdef INV_BYTE_SUB_FWD_EN
   input  logic       encrypt,
`endif
   output logic [7:0] dout
);

   // Table lookup for one byte
   always_comb begin
`ifdef INV_BYTE_SUB_FWD_EN
      dout = encrypt ? SBOX[din] : INV_SBOX[din];
`else
      dout = INV_SBOX[din];
`endif
   end

endmodule

// File: rtl/inv_byte_sub.sv
// Iterative AES InvSubBytes: accepts a 128-bit state, substitutes
// BYTES_PER_CYCLE bytes per cycle in place, then presents the result
// until the downstream handshake. INV_BYTE_SUB_FWD_EN adds an encrypt
// port selecting the forward Sbox for the whole operation.
`timescale 1ns/1ps
module inv_byte_sub
   import aes_pkg::*;
#(
   parameter int BYTES_PER_CYCLE = 4
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_STATE_W-1:0] in_data,
`ifdef INV_BYTE_SUB_FWD_EN
   input  logic                   encrypt,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_STATE_W-1:0] out_data
);

   // Counter step and the byte offset of the final BUSY slice (both mod 16)
   localparam logic [3:0] STEP = 4'(BYTES_PER_CYCLE % 16);
   localparam logic [3:0] LAST = 4'(16 - BYTES_PER_CYCLE);

   state_t                 state, state_nxt;
   logic [3:0]             cnt;
   logic [AES_STATE_W-1:0] st;
   logic [AES_STATE_W-1:0] st_sub;
   logic                   accept;
   logic                   mode;

   logic [3:0] idx    [BYTES_PER_CYCLE];
   logic [7:0] sb_in  [BYTES_PER_CYCLE];
   logic [7:0] sb_out [BYTES_PER_CYCLE];

`ifdef INV_BYTE_SUB_FWD_EN
   // Direction is latched at accept so it cannot change mid-operation
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         mode <= 1'b0;
      else if (accept) mode <= encrypt;
   end
`else
   assign mode = 1'b0;
`endif

   // Byte k of this slice is state byte cnt+k; shifting left brings it to the MSB byte
   for (genvar k = 0; k < BYTES_PER_CYCLE; k++) begin : g_lane
      logic [AES_STATE_W-1:0] shifted;
      assign idx[k]   = cnt + 4'(k);
      assign shifted  = st << {idx[k], 3'b000};
      assign sb_in[k] = shifted[AES_STATE_W-1 -: 8];
      inv_sbox u_sbox (
         .din     (sb_in[k]),
`ifdef INV_BYTE_SUB_FWD_EN
         .encrypt (mode),
`endif
         .dout    (sb_out[k])
      );
   end

   // Merge substituted bytes back into their positions via shifted byte masks
   always_comb begin
      st_sub = st;
      for (int unsigned k = 0; k < BYTES_PER_CYCLE; k++) begin
         st_sub = (st_sub & ~({8'hff, {(AES_STATE_W-8){1'b0}}} >> {idx[k], 3'b000}))
                | ({sb_out[k], {(AES_STATE_W-8){1'b0}}} >> {idx[k], 3'b000});
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and handshake outputs
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (in_valid) state_nxt = BUSY;
         end
         BUSY: begin
            if (cnt == LAST) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register and byte counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st  <= '0;
         cnt <= '0;
      end else if (accept) begin
         st  <= in_data;
         cnt <= '0;
      end else if (state == BUSY) begin
         st  <= st_sub;
         cnt <= (cnt == LAST) ? '0 : cnt + STEP;
      end
   end

   assign out_data = st;

endmodule
